// File: rtl/pulp_cluster_package.sv
// Constants shared by the cluster peripheral interconnect: slot map, mapped-slot mask
// and the data pattern returned for accesses to unmapped slots.
package pulp_cluster_package;

    localparam int NB_SPERIPHS = 8;

    localparam int SPER_EOC_ID      = 0;
    localparam int SPER_TIMER_ID    = 1;
    localparam int SPER_EVENT_U_ID  = 2;
    localparam int SPER_RESERVED_ID = 3;
    localparam int SPER_HWPE_ID     = 4;
    localparam int SPER_ICACHE_CTRL = 5;
    localparam int SPER_DMA_ID      = 6;
    localparam int SPER_EXT_ID      = 7;

    localparam logic [NB_SPERIPHS-1:0] SPER_VALID_MASK = 8'b1111_0111;
    localparam logic [31:0]            SPER_ERR_RDATA  = 32'hBADACCE5;

endpackage

// File: rtl/speriph_outstanding_tracker.sv
// Counts granted-but-unanswered accesses and remembers the target they went to.
// cur_tgt_o | meaning: MSB clear = slave index in low bits, MSB set = ERR (router answers)
module speriph_outstanding_tracker #(
    parameter int TGT_W           = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [TGT_W-1:0] tgt_i,
    input  logic             hs_i,
    input  logic             resp_i,
    output logic             can_accept_o,
    output logic [TGT_W-1:0] cur_tgt_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    assign can_accept_o = (cnt_o < CNT_MAX) && ((cnt_o == '0) || (tgt_i == cur_tgt_o));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o     <= '0;
            cur_tgt_o <= '0;
        end else begin
            if (hs_i) begin
                cur_tgt_o <= tgt_i;
            end
            case ({hs_i, resp_i})
                2'b10:   cnt_o <= cnt_o + CNT_W'(1);
                2'b01:   cnt_o <= cnt_o - CNT_W'(1);
                default: cnt_o <= cnt_o;
            endcase
        end
    end

endmodule

// File: rtl/cluster_speriph_router.sv
// Routes one master port onto the cluster peripheral slaves; responses stay in order
// because the target cannot change while any access is outstanding.
module cluster_speriph_router #(
    parameter int NB_SPERIPHS     = pulp_cluster_package::NB_SPERIPHS,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int SEL_LSB         = 10,
    parameter logic [NB_SPERIPHS-1:0] VALID_MASK = pulp_cluster_package::SPER_VALID_MASK
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    m_req_i,
    output logic                    m_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m_add_i,
    input  logic                    m_wen_i,
    input  logic [DATA_WIDTH-1:0]   m_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] m_be_i,
    input  logic [ID_WIDTH-1:0]     m_id_i,
    output logic                    m_r_valid_o,
    output logic [DATA_WIDTH-1:0]   m_r_rdata_o,
    output logic                    m_r_opc_o,
    output logic [ID_WIDTH-1:0]     m_r_id_o,
    output logic [NB_SPERIPHS-1:0]  s_req_o,
    input  logic [NB_SPERIPHS-1:0]  s_gnt_i,
    output logic [ADDR_WIDTH-1:0]   s_add_o   [NB_SPERIPHS],
    output logic [NB_SPERIPHS-1:0]  s_wen_o,
    output logic [DATA_WIDTH-1:0]   s_wdata_o [NB_SPERIPHS],
    output logic [DATA_WIDTH/8-1:0] s_be_o    [NB_SPERIPHS],
    output logic [ID_WIDTH-1:0]     s_id_o    [NB_SPERIPHS],
    input  logic [NB_SPERIPHS-1:0]  s_r_valid_i,
    input  logic [DATA_WIDTH-1:0]   s_r_rdata_i [NB_SPERIPHS],
    input  logic [NB_SPERIPHS-1:0]  s_r_opc_i,
    input  logic [ID_WIDTH-1:0]     s_r_id_i    [NB_SPERIPHS]
);

    localparam int IDX_W = $clog2(NB_SPERIPHS);
    localparam int TGT_W = IDX_W + 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [TGT_W-1:0]      TGT_ERR   = {1'b1, {IDX_W{1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(pulp_cluster_package::SPER_ERR_RDATA);

    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       cur_idx;
    logic [TGT_W-1:0]       tgt;
    logic [TGT_W-1:0]       cur_tgt;
    logic [CNT_W-1:0]       cnt;
    logic                   mapped;
    logic                   can_accept;
    logic                   accept;
    logic                   hs;
    logic                   resp;
    logic                   cur_err;
    logic                   err_pend_q;
    logic [ID_WIDTH-1:0]    err_id_q;
    logic [NB_SPERIPHS-1:0] expect_rvalid;

    assign idx     = m_add_i[SEL_LSB +: IDX_W];
    assign mapped  = VALID_MASK[idx];
    assign tgt     = mapped ? {1'b0, idx} : TGT_ERR;
    assign cur_err = cur_tgt[IDX_W];
    assign cur_idx = cur_tgt[IDX_W-1:0];

    // Reset gates the request path so nothing leaks out while rst_ni is held low.
    assign accept = rst_ni & can_accept;
    assign hs     = m_req_i & m_gnt_o;

    speriph_outstanding_tracker #(
        .TGT_W           (TGT_W),
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_tracker (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .tgt_i        (tgt),
        .hs_i         (hs),
        .resp_i       (resp),
        .can_accept_o (can_accept),
        .cur_tgt_o    (cur_tgt),
        .cnt_o        (cnt)
    );

    always_comb begin
        for (int i = 0; i < NB_SPERIPHS; i++) begin
            s_add_o[i]   = m_add_i;
            s_wdata_o[i] = m_wdata_i;
            s_be_o[i]    = m_be_i;
            s_id_o[i]    = m_id_i;
        end
    end
    assign s_wen_o = {NB_SPERIPHS{m_wen_i}};

    always_comb begin
        s_req_o = '0;
        m_gnt_o = 1'b0;
        if (accept) begin
            if (mapped) begin
                s_req_o[idx] = m_req_i;
                m_gnt_o      = s_gnt_i[idx];
            end else begin
                m_gnt_o = m_req_i;
            end
        end
    end

    always_comb begin
        resp        = 1'b0;
        m_r_opc_o   = 1'b0;
        m_r_rdata_o = '0;
        m_r_id_o    = '0;
        if (cur_err) begin
            if (err_pend_q) begin
                resp        = 1'b1;
                m_r_opc_o   = 1'b1;
                m_r_rdata_o = ERR_RDATA;
                m_r_id_o    = err_id_q;
            end
        end else if ((cnt != '0) && s_r_valid_i[cur_idx]) begin
            resp        = 1'b1;
            m_r_opc_o   = s_r_opc_i[cur_idx];
            m_r_rdata_o = s_r_rdata_i[cur_idx];
            m_r_id_o    = s_r_id_i[cur_idx];
        end
    end
    assign m_r_valid_o = resp;

    // Unmapped accesses always answer exactly one cycle after their grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_pend_q <= 1'b0;
            err_id_q   <= '0;
        end else begin
            err_pend_q <= hs & ~mapped;
            if (hs && !mapped) begin
                err_id_q <= m_id_i;
            end
        end
    end

    always_comb begin
        expect_rvalid = '0;
        if ((cnt != '0) && !cur_err) begin
            expect_rvalid[cur_idx] = 1'b1;
        end
    end

    a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (s_r_valid_i & ~expect_rvalid) == '0);

endmodule

// File: tb/tb_cluster_speriph_router.sv
// Bench for cluster_speriph_router: directed scenarios, then a randomized run checked
// against a queue of outstanding accesses.
module tb_cluster_speriph_router;

    localparam int NB   = 8;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int IW   = 8;
    localparam int MAXO = 4;
    localparam int ERR  = 8;
    localparam logic [NB-1:0] MAP = 8'b1111_0111;

    typedef struct {
        int            tgt;
        logic [IW-1:0] id;
    } txn_t;

    logic            clk_i  = 1'b0;
    logic            rst_ni = 1'b0;
    logic            m_req_i;
    logic            m_gnt_o;
    logic [AW-1:0]   m_add_i;
    logic            m_wen_i;
    logic [DW-1:0]   m_wdata_i;
    logic [DW/8-1:0] m_be_i;
    logic [IW-1:0]   m_id_i;
    logic            m_r_valid_o;
    logic [DW-1:0]   m_r_rdata_o;
    logic            m_r_opc_o;
    logic [IW-1:0]   m_r_id_o;
    logic [NB-1:0]   s_req_o;
    logic [NB-1:0]   s_gnt_i;
    logic [AW-1:0]   s_add_o   [NB];
    logic [NB-1:0]   s_wen_o;
    logic [DW-1:0]   s_wdata_o [NB];
    logic [DW/8-1:0] s_be_o    [NB];
    logic [IW-1:0]   s_id_o    [NB];
    logic [NB-1:0]   s_r_valid_i;
    logic [DW-1:0]   s_r_rdata_i [NB];
    logic [NB-1:0]   s_r_opc_i;
    logic [IW-1:0]   s_r_id_i    [NB];

    int   n_tests = 0;
    int   n_fail  = 0;
    txn_t pend[$];

    always #5 clk_i = ~clk_i;

    cluster_speriph_router #(
        .NB_SPERIPHS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
        .MAX_OUTSTANDING(MAXO), .SEL_LSB(10), .VALID_MASK(MAP)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_add_i(m_add_i), .m_wen_i(m_wen_i),
        .m_wdata_i(m_wdata_i), .m_be_i(m_be_i), .m_id_i(m_id_i),
        .m_r_valid_o(m_r_valid_o), .m_r_rdata_o(m_r_rdata_o), .m_r_opc_o(m_r_opc_o),
        .m_r_id_o(m_r_id_o),
        .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_add_o(s_add_o), .s_wen_o(s_wen_o),
        .s_wdata_o(s_wdata_o), .s_be_o(s_be_o), .s_id_o(s_id_o),
        .s_r_valid_i(s_r_valid_i), .s_r_rdata_i(s_r_rdata_i), .s_r_opc_i(s_r_opc_i),
        .s_r_id_i(s_r_id_i)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        m_req_i = 1'b0; m_add_i = '0; m_wen_i = 1'b0; m_wdata_i = '0; m_be_i = '0; m_id_i = '0;
        s_gnt_i = '0; s_r_valid_i = '0; s_r_opc_i = '0;
        for (int i = 0; i < NB; i++) begin
            s_r_rdata_i[i] = '0;
            s_r_id_i[i]    = '0;
        end
    endtask

    task automatic request(input int slave, input logic wen, input logic [IW-1:0] id);
        m_req_i   = 1'b1;
        m_add_i   = (AW'(slave) << 10) | AW'($urandom_range(0, 1023));
        m_wen_i   = wen;
        m_wdata_i = $urandom;
        m_be_i    = '1;
        m_id_i    = id;
    endtask

    task automatic respond(input int slave, input logic [IW-1:0] id, input logic [DW-1:0] data);
        s_r_valid_i        = '0;
        s_r_valid_i[slave] = 1'b1;
        s_r_rdata_i[slave] = data;
        s_r_id_i[slave]    = id;
        s_r_opc_i          = '0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle();
        m_req_i = 1'b1; m_add_i = 32'h0000_0400; s_gnt_i = '1; s_r_valid_i = '1; s_r_opc_i = '1;
        for (int i = 0; i < NB; i++) begin
            s_r_rdata_i[i] = $urandom | 32'h1;
            s_r_id_i[i]    = 8'hFF;
        end
        tick(); #2;
        n_tests++; if (m_gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", m_gnt_o); end
        n_tests++; if (s_req_o !== '0) begin n_fail++; $display("FAIL reset_sreq: got %b want 0", s_req_o); end
        n_tests++; if ({m_r_valid_o, m_r_opc_o} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid_opc: got %b%b want 00", m_r_valid_o, m_r_opc_o); end
        n_tests++; if ({m_r_rdata_o, m_r_id_o} !== '0) begin n_fail++; $display("FAIL reset_rdata_id: got %h/%h want 0/0", m_r_rdata_o, m_r_id_o); end
        idle(); #1; rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        logic [DW-1:0] d;
        idle(); request(1, 1'b1, 8'h11); s_gnt_i[1] = 1'b1; #2;
        n_tests++; if (m_gnt_o !== 1'b1 || s_req_o !== 8'b0000_0010) begin n_fail++; $display("FAIL single_req: gnt=%b sreq=%b want 1/00000010", m_gnt_o, s_req_o); end
        n_tests++; if (s_add_o[1] !== m_add_i || s_wen_o !== 8'hFF) begin n_fail++; $display("FAIL single_bcast: add=%h wen=%b want %h/11111111", s_add_o[1], s_wen_o, m_add_i); end
        tick();
        d = $urandom;
        idle(); respond(1, 8'h11, d); #2;
        n_tests++; if (m_r_valid_o !== 1'b1 || m_r_rdata_o !== d || m_r_id_o !== 8'h11) begin n_fail++; $display("FAIL single_resp: v=%b d=%h id=%h want 1/%h/11", m_r_valid_o, m_r_rdata_o, m_r_id_o, d); end
        tick();
        idle(); request(2, 1'b1, 8'h22); s_gnt_i[2] = 1'b1; #2;
        n_tests++; if (m_gnt_o !== 1'b1 || m_r_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_cnt_zero: gnt=%b v=%b want 1/0", m_gnt_o, m_r_valid_o); end
        tick();
        idle(); respond(2, 8'h22, $urandom); tick();
        idle();
    endtask

    task automatic test_outstanding_cap();
        for (int k = 0; k < 4; k++) begin
            idle(); request(6, 1'b0, IW'(k)); s_gnt_i[6] = 1'b1; #2;
            n_tests++; if (m_gnt_o !== 1'b1) begin n_fail++; $display("FAIL cap_grant%0d: got %b want 1", k, m_gnt_o); end
            tick();
        end
        idle(); request(6, 1'b0, 8'h04); s_gnt_i[6] = 1'b1; #2;
        n_tests++; if (m_gnt_o !== 1'b0 || s_req_o !== '0) begin n_fail++; $display("FAIL cap_hold: gnt=%b sreq=%b want 0/0", m_gnt_o, s_req_o); end
        tick();
        idle(); request(6, 1'b0, 8'h04); s_gnt_i[6] = 1'b1; respond(6, 8'h00, $urandom); #2;
        n_tests++; if (m_r_valid_o !== 1'b1 || m_r_id_o !== 8'h00 || m_gnt_o !== 1'b0) begin n_fail++; $display("FAIL cap_first_resp: v=%b id=%h gnt=%b want 1/00/0", m_r_valid_o, m_r_id_o, m_gnt_o); end
        tick();
        idle(); request(6, 1'b0, 8'h04); s_gnt_i[6] = 1'b1; respond(6, 8'h01, $urandom); #2;
        n_tests++; if (m_gnt_o !== 1'b1) begin n_fail++; $display("FAIL cap_regrant: got %b want 1", m_gnt_o); end
        tick();
        for (int k = 2; k <= 4; k++) begin
            idle(); respond(6, IW'(k), $urandom); #2;
            n_tests++; if (m_r_valid_o !== 1'b1 || m_r_id_o !== IW'(k)) begin n_fail++; $display("FAIL cap_drain%0d: v=%b id=%h want 1/%h", k, m_r_valid_o, m_r_id_o, IW'(k)); end
            tick();
        end
        idle();
    endtask

    task automatic test_switch_block();
        idle(); request(4, 1'b1, 8'h40); s_gnt_i[4] = 1'b1; #2;
        n_tests++; if (m_gnt_o !== 1'b1) begin n_fail++; $display("FAIL blk_first: got %b want 1", m_gnt_o); end
        tick();
        for (int k = 0; k < 2; k++) begin
            idle(); request(2, 1'b1, 8'h20); s_gnt_i[2] = 1'b1; #2;
            n_tests++; if (m_gnt_o !== 1'b0 || s_req_o !== '0) begin n_fail++; $display("FAIL blk_hold%0d: gnt=%b sreq=%b want 0/0", k, m_gnt_o, s_req_o); end
            tick();
        end
        idle(); request(2, 1'b1, 8'h20); s_gnt_i[2] = 1'b1; respond(4, 8'h40, $urandom); #2;
        n_tests++; if (m_r_valid_o !== 1'b1 || m_r_id_o !== 8'h40 || m_gnt_o !== 1'b0) begin n_fail++; $display("FAIL blk_resp: v=%b id=%h gnt=%b want 1/40/0", m_r_valid_o, m_r_id_o, m_gnt_o); end
        tick();
        s_r_valid_i = '0; #2;
        n_tests++; if (m_gnt_o !== 1'b1 || s_req_o !== 8'b0000_0100) begin n_fail++; $display("FAIL blk_switch: gnt=%b sreq=%b want 1/00000100", m_gnt_o, s_req_o); end
        tick();
        idle(); respond(2, 8'h20, $urandom); #2;
        n_tests++; if (m_r_valid_o !== 1'b1 || m_r_id_o !== 8'h20) begin n_fail++; $display("FAIL blk_second_resp: v=%b id=%h want 1/20", m_r_valid_o, m_r_id_o); end
        tick();
        idle();
    endtask

    task automatic test_err_resp();
        idle(); request(3, 1'b1, 8'h5A); #2;
        n_tests++; if (m_gnt_o !== 1'b1 || s_req_o !== '0) begin n_fail++; $display("FAIL err_grant: gnt=%b sreq=%b want 1/0", m_gnt_o, s_req_o); end
        tick();
        idle(); #2;
        n_tests++; if (m_r_valid_o !== 1'b1 || m_r_opc_o !== 1'b1 || m_r_rdata_o !== 32'hBADACCE5 || m_r_id_o !== 8'h5A) begin
            n_fail++; $display("FAIL err_resp: v=%b opc=%b d=%h id=%h want 1/1/badacce5/5a", m_r_valid_o, m_r_opc_o, m_r_rdata_o, m_r_id_o);
        end
        tick(); #2;
        n_tests++; if (m_r_valid_o !== 1'b0) begin n_fail++; $display("FAIL err_single: got %b want 0", m_r_valid_o); end
        tick();
    endtask

    task automatic test_same_cycle();
        for (int k = 0; k < 2; k++) begin
            idle(); request(1, 1'b0, IW'(k)); s_gnt_i[1] = 1'b1; tick();
        end
        idle(); request(1, 1'b0, 8'h02); s_gnt_i[1] = 1'b1; respond(1, 8'h00, $urandom); #2;
        n_tests++; if (m_gnt_o !== 1'b1 || m_r_valid_o !== 1'b1) begin n_fail++; $display("FAIL same_cycle: gnt=%b v=%b want 1/1", m_gnt_o, m_r_valid_o); end
        tick();
        for (int k = 3; k <= 5; k++) begin
            idle(); request(1, 1'b0, IW'(k)); s_gnt_i[1] = 1'b1; #2;
            n_tests++; if (m_gnt_o !== (k < 5)) begin n_fail++; $display("FAIL same_fill%0d: got %b want %b", k, m_gnt_o, (k < 5)); end
            tick();
        end
        for (int k = 1; k <= 4; k++) begin
            idle(); respond(1, IW'(k), $urandom); tick();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            idle(); request(5, 1'b1, IW'(k)); s_gnt_i[5] = 1'b1; tick();
        end
        idle(); request(5, 1'b1, 8'h33); s_gnt_i[5] = 1'b1; respond(5, 8'h00, 32'hCAFE_0001); #2;
        n_tests++; if (m_gnt_o !== 1'b1 || m_r_valid_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre: gnt=%b v=%b want 1/1", m_gnt_o, m_r_valid_o); end
        rst_ni = 1'b0; #1;
        n_tests++; if ({m_gnt_o, s_req_o, m_r_valid_o, m_r_opc_o} !== '0 || {m_r_rdata_o, m_r_id_o} !== '0) begin
            n_fail++; $display("FAIL rst_async: gnt=%b sreq=%b v=%b opc=%b d=%h id=%h want all 0", m_gnt_o, s_req_o, m_r_valid_o, m_r_opc_o, m_r_rdata_o, m_r_id_o);
        end
        tick(); #2;
        n_tests++; if (m_r_valid_o !== 1'b0 || m_r_rdata_o !== '0) begin n_fail++; $display("FAIL rst_stale: v=%b d=%h want 0/0", m_r_valid_o, m_r_rdata_o); end
        idle(); #1; rst_ni = 1'b1;
        tick();
        idle(); request(2, 1'b1, 8'h77); s_gnt_i[2] = 1'b1; #2;
        n_tests++; if (m_gnt_o !== 1'b1 || s_req_o !== 8'b0000_0100) begin n_fail++; $display("FAIL rst_cnt_zero: gnt=%b sreq=%b want 1/00000100", m_gnt_o, s_req_o); end
        tick();
        idle(); respond(2, 8'h77, $urandom); tick();
        idle();
    endtask

    task automatic test_random();
        int last_tgt;
        bit req_on;
        int req_slot;
        last_tgt = 0;
        req_on   = 1'b0;
        pend.delete();
        idle();
        for (int cyc = 0; cyc < 600; cyc++) begin
            int            t;
            bit            acc;
            bit            egnt;
            bit            evalid;
            bit            eopc;
            bit            slv_resp;
            logic [DW-1:0] erdata;
            logic [IW-1:0] eid;
            logic [NB-1:0] esreq;
            if (!req_on && $urandom_range(0, 2) != 0) begin
                req_on   = 1'b1;
                req_slot = ($urandom_range(0, 1) == 1) ? ((last_tgt == ERR) ? 3 : last_tgt) : int'($urandom_range(0, 7));
                m_req_i   = 1'b1;
                m_add_i   = ($urandom & ~32'h0000_1C00) | (AW'(req_slot) << 10);
                m_wen_i   = 1'($urandom);
                m_wdata_i = $urandom;
                m_be_i    = 4'($urandom);
                m_id_i    = IW'($urandom);
            end
            s_gnt_i   = NB'($urandom);
            s_r_opc_i = NB'($urandom);
            for (int i = 0; i < NB; i++) begin
                s_r_rdata_i[i] = $urandom;
                s_r_id_i[i]    = IW'($urandom);
            end
            s_r_valid_i = '0;
            slv_resp    = 1'b0;
            if (pend.size() > 0 && pend[0].tgt != ERR && $urandom_range(0, 2) != 0) begin
                slv_resp                  = 1'b1;
                s_r_valid_i[pend[0].tgt]  = 1'b1;
                s_r_id_i[pend[0].tgt]     = pend[0].id;
            end

            t     = MAP[m_add_i[12:10]] ? int'(m_add_i[12:10]) : ERR;
            acc   = (pend.size() < MAXO) && (pend.size() == 0 || t == last_tgt);
            egnt  = acc && ((t == ERR) ? m_req_i : s_gnt_i[t]);
            esreq = '0;
            if (acc && t != ERR && m_req_i) esreq[t] = 1'b1;
            evalid = 1'b0; eopc = 1'b0; erdata = '0; eid = '0;
            if (pend.size() > 0 && pend[0].tgt == ERR) begin
                evalid = 1'b1; eopc = 1'b1; erdata = 32'hBADACCE5; eid = pend[0].id;
            end else if (slv_resp) begin
                evalid = 1'b1; eopc = s_r_opc_i[pend[0].tgt]; erdata = s_r_rdata_i[pend[0].tgt]; eid = pend[0].id;
            end
            #2;
            n_tests++; if (m_gnt_o !== egnt) begin n_fail++; $display("FAIL rnd_gnt cyc=%0d: got %b want %b", cyc, m_gnt_o, egnt); end
            n_tests++; if (s_req_o !== esreq) begin n_fail++; $display("FAIL rnd_sreq cyc=%0d: got %b want %b", cyc, s_req_o, esreq); end
            n_tests++; if (m_r_valid_o !== evalid) begin n_fail++; $display("FAIL rnd_rvalid cyc=%0d: got %b want %b", cyc, m_r_valid_o, evalid); end
            if (evalid) begin
                n_tests++; if ({m_r_opc_o, m_r_rdata_o, m_r_id_o} !== {eopc, erdata, eid}) begin
                    n_fail++; $display("FAIL rnd_resp cyc=%0d: got %b/%h/%h want %b/%h/%h", cyc, m_r_opc_o, m_r_rdata_o, m_r_id_o, eopc, erdata, eid);
                end
                void'(pend.pop_front());
            end
            if (m_req_i && egnt) begin
                pend.push_back('{t, m_id_i});
                last_tgt = t;
                req_on   = 1'b0;
            end
            tick();
            if (!req_on) m_req_i = 1'b0;
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_single_read();
        test_outstanding_cap();
        test_switch_block();
        test_err_resp();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cluster_speriph_router.md
CLUSTER_SPERIPH_ROUTER -- requirements
Module: cluster_speriph_router

Interface
REQ-001 SHALL have parameter NB_SPERIPHS, default 8, number of peripheral slave ports.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, request address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width; byte-enable width is DATA_WIDTH/8.
REQ-004 SHALL have parameter ID_WIDTH, default 8, transaction ID width.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 4, cap on granted-but-unanswered transactions.
REQ-006 SHALL have parameter SEL_LSB, default 10, LSB of the slave-select field; each slave owns a 1 KiB window.
REQ-007 SHALL have parameter VALID_MASK, default 8'b1111_0111, bit i set means slave index i is mapped; index 3 is unmapped.
REQ-008 Ports: clk_i, in, 1, cluster clock; sole clock of the block.
REQ-009 Ports: rst_ni, in, 1, asynchronous active-low reset.
REQ-010 Ports: m_req_i/m_gnt_o, in/out, 1/1, master request and grant.
REQ-011 Ports: m_add_i, m_wen_i, m_wdata_i, m_be_i, m_id_i, in, ADDR_WIDTH/1/DATA_WIDTH/DATA_WIDTH/8/ID_WIDTH, request payload; m_wen_i=1 means read.
REQ-012 Ports: m_r_valid_o, m_r_rdata_o, m_r_opc_o, m_r_id_o, out, 1/DATA_WIDTH/1/ID_WIDTH, response to master.
REQ-013 Ports: s_req_o/s_gnt_i, out/in, NB_SPERIPHS each, per-slave request and grant.
REQ-014 Ports: s_add_o, s_wen_o, s_wdata_o, s_be_o, s_id_o, out, per-slave arrays, master payload broadcast to all slaves.
REQ-015 Ports: s_r_valid_i, s_r_rdata_i, s_r_opc_i, s_r_id_i, in, per-slave arrays, slave responses.

Function
REQ-016 Target index SHALL be m_add_i[SEL_LSB+$clog2(NB_SPERIPHS)-1:SEL_LSB].
REQ-017 A mapped request SHALL be forwarded combinationally: s_req_o[idx]=m_req_i&accept and m_gnt_o=s_gnt_i[idx]&accept.
REQ-018 accept SHALL be 1 iff cnt<MAX_OUTSTANDING and (cnt==0 or idx==cur_tgt).
REQ-019 When accept is 0, all s_req_o SHALL be 0 and m_gnt_o SHALL be 0; the master holds its request.
REQ-020 On each handshake (m_req_i&m_gnt_o), cur_tgt SHALL load idx and cnt SHALL increment.
REQ-021 The response mux SHALL select slave cur_tgt: m_r_valid_o, m_r_rdata_o, m_r_opc_o and m_r_id_o SHALL equal that slave's signals.
REQ-022 Each cycle with m_r_valid_o=1 SHALL decrement cnt; a handshake and a response in the same cycle SHALL leave cnt unchanged.
REQ-023 An unmapped request SHALL be granted by the router itself when accept=1, with cur_tgt set to the ERR state.
REQ-024 In ERR state, exactly one cycle after the grant, the router SHALL drive m_r_valid_o=1, m_r_opc_o=1, m_r_rdata_o=32'hBADACCE5 and m_r_id_o=the captured m_id_i.
REQ-025 A slave r_valid arriving while cnt==0, or from a slave other than cur_tgt, SHALL be ignored and SHALL raise a simulation assertion.
REQ-026 Request-to-response order SHALL be preserved because target switching is blocked while cnt>0.

Reset
REQ-027 On rst_ni low, cnt SHALL be 0 and cur_tgt SHALL be 0, with the ERR response pending flag cleared.
REQ-028 During reset, m_gnt_o, m_r_valid_o, m_r_opc_o and all s_req_o SHALL be 0, and m_r_rdata_o and m_r_id_o SHALL be 0.
REQ-029 Reset mid-transaction SHALL drop outstanding state; late slave responses after reset SHALL fall under REQ-025.

Structure
REQ-030 SPER_* slot indices, NB_SPERIPHS, VALID_MASK default and the error pattern constant SHALL live in pulp_cluster_package.
REQ-031 Counter and target tracking SHALL be a sub-module speriph_outstanding_tracker; decode and muxing stay in the top.

Verification
REQ-032 Read add=0x0000_0400 (slave 1), gnt at cycle 0, r_valid at cycle 1 -> one s_req_o[1] pulse, response forwarded, cnt 1->0.
REQ-033 Four back-to-back writes to slave 6 with no responses -> four grants, fifth held with m_gnt_o=0 until the first response.
REQ-034 Request to slave 2 while one slave-4 access is outstanding -> no grant until the slave-4 response, then slave-2 granted in the same cycle cnt reaches 0.
REQ-035 Read add=0x0000_0C00 (index 3) with id=0x5A -> grant at cycle 0; at cycle 1 r_valid=1, opc=1, rdata=0xBADACCE5, r_id=0x5A.
REQ-036 Handshake and response in the same cycle at cnt=2 -> cnt stays 2.
REQ-037 rst_ni asserted with cnt=3 -> cnt=0 and all outputs 0 asynchronously; an injected stale r_valid fires the assertion and is not forwarded.
